ps2_key_decoder: RTL and testbench

PS/2 keyboard receiver and scan-code decoder that sits directly upstream of the VGA/game controller. Samples the raw keyboard clock/data lines, deframes 11-bit PS/2 frames, tracks E0/F0 prefixes, and presents the last code byte, a make/break indication, and per-arrow "key held" flags that drive player movement. It replaces equality tests on a raw byte with level flags that stay asserted while a key is physically down.

---
 rtl/ps2_key_decoder.sv | 153 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes keyclk/keyinput, deframes 11-bit frames, tracks E0/F0
// prefixes and keeps per-arrow held flags. Optional odd-parity checking under PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyclk,
    input  logic       keyinput,
    output logic [7:0] last_code,
    output logic       code_valid,
    output logic       key_break,
    output logic [3:0] dir_held,
    output logic       frame_err,
    output logic [4:0] debug_state   // {ext, brk, parity bit, frame state}
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_n;
    logic [2:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shift, shift_n;
    logic            par, par_n;
    logic [TW-1:0]   to_cnt;
    logic            ext, brk;
    logic            fall, bit_in, par_ok, timeout, byte_ok, frm_bad;
    logic [3:0]      arrow_mask;

    // Sync flops reset high so a released reset never looks like a keyclk falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], keyclk};
            dat_sync <= {dat_sync[0], keyinput};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shift, par};
`else
    assign par_ok = 1'b1;
`endif

    assign timeout = (state != S_IDLE) && !fall && (to_cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par     <= par_n;
            if (state == S_IDLE || fall || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        byte_ok   = 1'b0;
        frm_bad   = 1'b0;
        if (timeout) begin
            state_n = S_IDLE;
            frm_bad = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE: if (!bit_in) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                end
                S_DATA: begin
                    shift_n   = {bit_in, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_PARITY;
                end
                S_PARITY: begin
                    par_n   = bit_in;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (bit_in && par_ok) byte_ok = 1'b1;
                    else                  frm_bad = 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (shift)
            8'h75:   arrow_mask = 4'b1000;
            8'h72:   arrow_mask = 4'b0100;
            8'h6B:   arrow_mask = 4'b0010;
            8'h74:   arrow_mask = 4'b0001;
            default: arrow_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_code  <= 8'h00;
            code_valid <= 1'b0;
            key_break  <= 1'b0;
            dir_held   <= 4'b0000;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            key_break  <= 1'b0;
            frame_err  <= frm_bad;
            if (frm_bad) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_ok) begin
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    last_code  <= shift;
                    code_valid <= 1'b1;
                    key_break  <= brk;
                    dir_held   <= brk ? (dir_held & ~arrow_mask) : (dir_held | arrow_mask);
                    ext        <= 1'b0;
                    brk        <= 1'b0;
                end
            end
        end
    end

    assign debug_state = {ext, brk, par, state};
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a byte-level reference model.
module tb_ps2_key_decoder;
    localparam int T    = 200;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst, keyclk, keyinput;
    logic [7:0] last_code;
    logic       code_valid, key_break, frame_err;
    logic [3:0] dir_held;
    logic [4:0] debug_state;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .keyclk(keyclk), .keyinput(keyinput),
        .last_code(last_code), .code_valid(code_valid), .key_break(key_break),
        .dir_held(dir_held), .frame_err(frame_err), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int err_exp = 0, err_seen = 0;
    logic [12:0] exp_q[$];   // {code, break, dir after the code}
    logic [3:0]  m_dir = 4'b0000;
    logic        m_brk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] arrow_of(input logic [7:0] b);
        logic [7:0] codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
        arrow_of = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (b == codes[i]) arrow_of = 4'b1000 >> i;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_brk = 1'b0;
            err_exp++;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE0) begin
            if (m_brk) m_dir = m_dir & ~arrow_of(b);
            else       m_dir = m_dir | arrow_of(b);
            exp_q.push_back({b, m_brk, m_dir});
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        keyinput = b;
        repeat (HALF) @(negedge clk);
        keyclk = 1'b0;
        repeat (HALF) @(negedge clk);
        keyclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        bit   good;
        p = (~^b) ^ bad_par;
`ifdef PS2_PARITY_CHECK_EN
        good = !bad_par && !bad_stop;
`else
        good = !bad_stop;
`endif
        model_byte(b, good);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(!bad_stop);
        keyinput = 1'b1;
        repeat (8) @(negedge clk);
        check("dir_after_frame", dir_held, m_dir);
    endtask

    always @(negedge clk) begin
        if (code_valid) begin
            if (exp_q.size() == 0) begin
                check("cv_unexpected", code_valid, 0);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("last_code", last_code, e[12:5]);
                check("key_break", key_break, e[4]);
                check("dir_on_cv", dir_held, e[3:0]);
            end
        end else if (key_break) begin
            check("kb_without_cv", key_break, 0);
        end
        if (frame_err) err_seen++;
    end

    task automatic timeout_test();
        int k;
        m_brk = 1'b0;
        err_exp++;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(i[0]);
        keyinput = 1'b1;
        repeat (HALF) @(negedge clk);
        keyclk = 1'b0;
        k = 0;
        while (k < T + 20) begin
            @(negedge clk);
            k++;
            if (k == HALF) keyclk = 1'b1;
            if (frame_err) break;
        end
        keyclk = 1'b1;
        check("timeout_latency_ok", (k >= T + 2 && k <= T + 4), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_test();
        send_frame(8'h74, 0, 0);
        check("dir_before_rst", dir_held, 4'b0001);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_last_code", last_code, 8'h00);
        check("rst_dir", dir_held, 4'b0000);
        check("rst_cv", code_valid, 0);
        check("rst_kb", key_break, 0);
        check("rst_ferr", frame_err, 0);
        repeat (3) @(negedge clk);
        keyclk = 1'b1;
        keyinput = 1'b1;
        rst = 1'b0;
        m_dir = 4'b0000;
        m_brk = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h74, 0, 0);
        check("dir_after_rst_frame", dir_held, 4'b0001);
    endtask

    initial begin
        logic [7:0] pool [7] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C};
        rst = 1'b1;
        keyclk = 1'b1;
        keyinput = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_last_code", last_code, 8'h00);
        check("reset_dir", dir_held, 4'b0000);
        check("reset_ferr", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(8'h75, 0, 0);
        check("make_up", dir_held, 4'b1000);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        check("break_up", dir_held, 4'b0000);
        send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        send_frame(8'h6B, 0, 0); send_frame(8'h75, 0, 0);
        check("left_up", dir_held, 4'b1010);
        send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
        check("up_only", dir_held, 4'b1000);
        send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        send_frame(8'h1C, 1, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h72, 0, 1);
        send_frame(8'h72, 0, 0);
        timeout_test();
        send_frame(8'h72, 0, 0);
        check("down_after_timeout", dir_held & 4'b0100, 4'b0100);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 6)];
            send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        send_frame(8'hF0, 0, 0); send_frame(8'h72, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h74, 0, 0);
        reset_test();

        repeat (20) @(negedge clk);
        check("pending_codes", exp_q.size(), 0);
        check("frame_err_count", err_seen, err_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
